// File: rtl/video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_timing_pkg                                                 |
// | Purpose  : Shared raster-timing types, standard mode constants and helpers  |
// |            for the video timing generator and its per-axis counters.        |
// | Contents : timing_t record {active, fp, sync, bp}, 800x600@60 and 640x480@60 |
// |            axis constants, total() helper returning the axis period.        |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package video_timing_pkg;

  // One raster axis: visible span, front porch, sync width, back porch.
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  // 800x600@60, 40 MHz pixel clock.
  localparam timing_t c_SVGA_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam timing_t c_SVGA_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  // 640x480@60, 25.175 MHz pixel clock.
  localparam timing_t c_VGA_640X480_H  = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam timing_t c_VGA_640X480_V  = '{active: 480, fp: 10, sync: 2,   bp: 33};

  // Full axis period in pixels (horizontal) or lines (vertical).
  function automatic int unsigned total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_timing_if                                                  |
// | Purpose  : Raster output bundle from the timing generator to the pixel      |
// |            pipeline.                                                        |
// | Ports    : hsync, vsync, videoActive, hPos[POS_W], vPos[POS_W], lineStart,  |
// |            frameStart, frameCount[FRAME_CNT_W]                              |
// |            master = generator side (drives), slave = consumer side.         |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
interface video_timing_if #(
  parameter int POS_W       = 11,
  parameter int FRAME_CNT_W = 8
);
  logic                   hsync;
  logic                   vsync;
  logic                   videoActive;
  logic [POS_W-1:0]       hPos;
  logic [POS_W-1:0]       vPos;
  logic                   lineStart;
  logic                   frameStart;
  logic [FRAME_CNT_W-1:0] frameCount;

  modport master (
    output hsync, vsync, videoActive, hPos, vPos, lineStart, frameStart, frameCount
  );

  modport slave (
    input  hsync, vsync, videoActive, hPos, vPos, lineStart, frameStart, frameCount
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : timing_axis                                                      |
// | Purpose  : One raster axis: wrapping position counter plus sync/active      |
// |            decode of the current count.                                     |
// | Ports    : clk40, resetN (sync, active-low), advance (count one step),      |
// |            clear (force to 0), cnt, wrap (cnt is last position),            |
// |            inSync (cnt inside sync window), active (cnt visible),           |
// |            pos (cnt while visible, else 0)                                  |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module timing_axis
  import video_timing_pkg::*;
#(
  parameter timing_t TIMING = c_SVGA_800X600_H,
  parameter int      W      = 11
) (
  input  logic         clk40,
  input  logic         resetN,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         inSync,
  output logic         active,
  output logic [W-1:0] pos
);

  // Every bound is below total(), and the back porch is non-zero, so all of
  // them fit in W bits whenever 2**W >= total().
  localparam logic [W-1:0] c_LAST       = W'(total(TIMING) - 1);
  localparam logic [W-1:0] c_ACTIVE     = W'(TIMING.active);
  localparam logic [W-1:0] c_SYNC_START = W'(TIMING.active + TIMING.fp);
  localparam logic [W-1:0] c_SYNC_END   = W'(TIMING.active + TIMING.fp + TIMING.sync);

  logic [W-1:0] r_cnt;
  logic         w_wrap;
  logic         w_active;

  assign w_wrap   = (r_cnt == c_LAST);
  assign w_active = (r_cnt < c_ACTIVE);

  always_ff @(posedge clk40) begin
    if (!resetN || clear) begin
      r_cnt <= '0;
    end else if (advance) begin
      r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = w_wrap;
  assign inSync = (r_cnt >= c_SYNC_START) && (r_cnt < c_SYNC_END);
  assign active = w_active;
  assign pos    = w_active ? r_cnt : '0;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_timing_gen                                                 |
// | Purpose  : Parametrised raster timing generator (hsync/vsync, active flag,  |
// |            pixel position, line/frame strobes, frame counter) with an       |
// |            output delay line for pipeline alignment.                        |
// | Ports    : clk40 (pixel clock), resetN (sync, active-low), enable (run;     |
// |            0 holds counters at origin), vid (video_timing_if.master)        |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned H_FP        = 40,
  parameter int unsigned H_SYNC      = 128,
  parameter int unsigned H_BP        = 88,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned V_FP        = 1,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BP        = 23,
  parameter bit          HSYNC_POL   = 1'b1,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter int          POS_W       = 11,
  parameter int          FRAME_CNT_W = 8,
  parameter int          OUT_DELAY   = 0
) (
  input  logic clk40,
  input  logic resetN,
  input  logic enable,
  video_timing_if.master vid
);

  localparam timing_t     c_H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t     c_V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned c_H_TOTAL  = total(c_H_TIMING);
  localparam int unsigned c_V_TOTAL  = total(c_V_TIMING);

  // Elaboration-time parameter checks.
  if ((64'd1 << POS_W) < 64'(c_H_TOTAL) || (64'd1 << POS_W) < 64'(c_V_TOTAL)) begin : g_err_pos_w
    $error("video_timing_gen: POS_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (OUT_DELAY < 0 || OUT_DELAY > 7) begin : g_err_delay
    $error("video_timing_gen: OUT_DELAY must be 0..7");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_porch
    $error("video_timing_gen: porch and sync parameters must be non-zero");
  end

  typedef struct packed {
    logic                   hsync;
    logic                   vsync;
    logic                   videoActive;
    logic [POS_W-1:0]       hPos;
    logic [POS_W-1:0]       vPos;
    logic                   lineStart;
    logic                   frameStart;
    logic [FRAME_CNT_W-1:0] frameCount;
  } vec_t;

  logic [POS_W-1:0]       w_hCnt, w_vCnt, w_hPos, w_vPos;
  logic                   w_hWrap, w_vWrap, w_hSync, w_vSync, w_hActive, w_vActive;
  logic [FRAME_CNT_W-1:0] r_frameCount;
  vec_t                   w_rstVec, w_decVec, r_dec, w_out;

  timing_axis #(.TIMING(c_H_TIMING), .W(POS_W)) u_hAxis (
    .clk40   (clk40),
    .resetN  (resetN),
    .advance (enable),
    .clear   (!enable),
    .cnt     (w_hCnt),
    .wrap    (w_hWrap),
    .inSync  (w_hSync),
    .active  (w_hActive),
    .pos     (w_hPos)
  );

  // The line counter steps only on the last pixel of a line.
  timing_axis #(.TIMING(c_V_TIMING), .W(POS_W)) u_vAxis (
    .clk40   (clk40),
    .resetN  (resetN),
    .advance (enable && w_hWrap),
    .clear   (!enable),
    .cnt     (w_vCnt),
    .wrap    (w_vWrap),
    .inSync  (w_vSync),
    .active  (w_vActive),
    .pos     (w_vPos)
  );

  // Completed-frame count: bumps on the edge that wraps both counters.
  always_ff @(posedge clk40) begin
    if (!resetN) begin
      r_frameCount <= '0;
    end else if (enable && w_hWrap && w_vWrap) begin
      r_frameCount <= r_frameCount + FRAME_CNT_W'(1);
    end
  end

  // Decode of the current (h,v). While disabled the inactive vector is sent,
  // carrying the held frame count so consumers never see it jump.
  always_comb begin
    w_rstVec       = '0;
    w_rstVec.hsync = ~HSYNC_POL;
    w_rstVec.vsync = ~VSYNC_POL;

    w_decVec            = w_rstVec;
    w_decVec.frameCount = r_frameCount;
    if (enable) begin
      w_decVec.hsync       = w_hSync ? HSYNC_POL : ~HSYNC_POL;
      w_decVec.vsync       = w_vSync ? VSYNC_POL : ~VSYNC_POL;
      w_decVec.videoActive = w_hActive && w_vActive;
      w_decVec.hPos        = w_hPos;
      w_decVec.vPos        = w_vPos;
      w_decVec.lineStart   = (w_hCnt == '0);
      w_decVec.frameStart  = (w_hCnt == '0) && (w_vCnt == '0);
    end
  end

  // Output register: gives the base one-cycle latency.
  always_ff @(posedge clk40) begin
    if (!resetN) begin
      r_dec <= w_rstVec;
    end else begin
      r_dec <= w_decVec;
    end
  end

  // Optional alignment delay; every stage flushes to inactive on reset.
  if (OUT_DELAY == 0) begin : g_bypass
    assign w_out = r_dec;
  end else begin : g_delay
    for (genvar i = 0; i < OUT_DELAY; i++) begin : g_stage
      vec_t r_q;
      vec_t w_d;
      if (i == 0) begin : g_src
        assign w_d = r_dec;
      end else begin : g_src
        assign w_d = g_stage[i-1].r_q;
      end
      always_ff @(posedge clk40) begin
        if (!resetN) begin
          r_q <= w_rstVec;
        end else begin
          r_q <= w_d;
        end
      end
    end
    assign w_out = g_stage[OUT_DELAY-1].r_q;
  end

  assign vid.hsync       = w_out.hsync;
  assign vid.vsync       = w_out.vsync;
  assign vid.videoActive = w_out.videoActive;
  assign vid.hPos        = w_out.hPos;
  assign vid.vPos        = w_out.vPos;
  assign vid.lineStart   = w_out.lineStart;
  assign vid.frameStart  = w_out.frameStart;
  assign vid.frameCount  = w_out.frameCount;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_video_timing_gen                                              |
// | Purpose  : Scoreboard bench for video_timing_gen. Two small raster configs  |
// |            (negative sync with 2-stage delay, mixed polarity undelayed)     |
// |            share clock, reset and enable; a raster reference model queues   |
// |            the expected output vector per edge and a monitor compares.      |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_video_timing_gen;

  typedef struct {
    int hAct, hFp, hSyn, hBp;
    int vAct, vFp, vSyn, vBp;
    bit hPol, vPol;
    int dly, fcw;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [15:0] hpos;
    logic [15:0] vpos;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } exp_t;

  logic clk40  = 1'b0;
  logic resetN = 1'b0;
  logic enable = 1'b0;

  always #5 clk40 = ~clk40;

  video_timing_if #(.POS_W(3), .FRAME_CNT_W(2)) ifA ();
  video_timing_if #(.POS_W(5), .FRAME_CNT_W(3)) ifB ();

  // A: H 4/1/2/1, V 3/1/1/1, both syncs active-low, 2 delay stages, POS_W at its limit.
  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .POS_W(3), .FRAME_CNT_W(2), .OUT_DELAY(2)
  ) dutA (
    .clk40  (clk40),
    .resetN (resetN),
    .enable (enable),
    .vid    (ifA)
  );

  // B: H 16/3/5/4, V 6/2/2/3, hsync active-high, vsync active-low, no delay.
  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .POS_W(5), .FRAME_CNT_W(3), .OUT_DELAY(0)
  ) dutB (
    .clk40  (clk40),
    .resetN (resetN),
    .enable (enable),
    .vid    (ifB)
  );

  cfg_t cfg [2];
  int   mh  [2];
  int   mv  [2];
  int   mfc [2];
  exp_t qA[$];
  exp_t qB[$];
  bit   run    = 1'b0;
  int   nTests = 0;
  int   nFail  = 0;
  int   cyc    = 0;

  // ---------------- reference model ----------------
  function automatic exp_t idleRef(cfg_t c, int fc);
    exp_t e;
    e      = '0;
    e.hs   = ~c.hPol;
    e.vs   = ~c.vPol;
    e.fc   = 8'(fc);
    return e;
  endfunction

  function automatic exp_t rasterRef(cfg_t c, int h, int v, int fc);
    exp_t e;
    int hs0, vs0;
    hs0    = c.hAct + c.hFp;
    vs0    = c.vAct + c.vFp;
    e.hs   = (h >= hs0 && h < hs0 + c.hSyn) ? c.hPol : ~c.hPol;
    e.vs   = (v >= vs0 && v < vs0 + c.vSyn) ? c.vPol : ~c.vPol;
    e.act  = (h < c.hAct) && (v < c.vAct);
    e.hpos = 16'((h < c.hAct) ? h : 0);
    e.vpos = 16'((v < c.vAct) ? v : 0);
    e.ls   = (h == 0);
    e.fs   = (h == 0) && (v == 0);
    e.fc   = 8'(fc);
    return e;
  endfunction

  task automatic pushExp(input int id, input exp_t e);
    if (id == 0) qA.push_back(e);
    else         qB.push_back(e);
  endtask

  // Apply one clock edge's inputs to the model and queue what that edge
  // (plus the configured delay) must show on the outputs.
  task automatic modelEdge(input int id, input bit rn, input bit en);
    cfg_t c;
    c = cfg[id];
    if (!rn) begin
      mh[id] = 0; mv[id] = 0; mfc[id] = 0;
      // Reset flushes every pending output: outputs are inactive from this
      // edge through the length of the delay line.
      if (id == 0) qA.delete();
      else         qB.delete();
      for (int k = 0; k <= c.dly; k++) pushExp(id, idleRef(c, 0));
    end else if (!en) begin
      pushExp(id, idleRef(c, mfc[id]));
      mh[id] = 0; mv[id] = 0;
    end else begin
      pushExp(id, rasterRef(c, mh[id], mv[id], mfc[id]));
      mh[id]++;
      if (mh[id] == c.hAct + c.hFp + c.hSyn + c.hBp) begin
        mh[id] = 0;
        mv[id]++;
        if (mv[id] == c.vAct + c.vFp + c.vSyn + c.vBp) begin
          mv[id]  = 0;
          mfc[id] = (mfc[id] + 1) % (1 << c.fcw);
        end
      end
    end
  endtask

  task automatic drive(input bit rn, input bit en);
    @(negedge clk40);
    resetN = rn;
    enable = en;
    modelEdge(0, rn, en);
    modelEdge(1, rn, en);
    run = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic compare(input string nm, input exp_t got, input exp_t want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b act=%b h=%0d v=%0d ls=%b fs=%b fc=%0d want hs=%b vs=%b act=%b h=%0d v=%0d ls=%b fs=%b fc=%0d",
               nm, cyc, got.hs, got.vs, got.act, got.hpos, got.vpos, got.ls, got.fs, got.fc,
               want.hs, want.vs, want.act, want.hpos, want.vpos, want.ls, want.fs, want.fc);
    end
  endtask

  always @(posedge clk40) begin
    exp_t gotA, gotB;
    #1;
    if (run) begin
      cyc++;
      gotA = '{hs: ifA.hsync, vs: ifA.vsync, act: ifA.videoActive,
               hpos: 16'(ifA.hPos), vpos: 16'(ifA.vPos),
               ls: ifA.lineStart, fs: ifA.frameStart, fc: 8'(ifA.frameCount)};
      gotB = '{hs: ifB.hsync, vs: ifB.vsync, act: ifB.videoActive,
               hpos: 16'(ifB.hPos), vpos: 16'(ifB.vPos),
               ls: ifB.lineStart, fs: ifB.frameStart, fc: 8'(ifB.frameCount)};
      if (qA.size() == 0) begin
        nTests++; nFail++;
        $display("FAIL dutA no expectation queued cyc=%0d got hs=%b want an entry", cyc, gotA.hs);
      end else begin
        compare("dutA", gotA, qA.pop_front());
      end
      if (qB.size() == 0) begin
        nTests++; nFail++;
        $display("FAIL dutB no expectation queued cyc=%0d got hs=%b want an entry", cyc, gotB.hs);
      end else begin
        compare("dutB", gotB, qB.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int dis;
    bit rn, en;
    cfg[0] = '{hAct: 4,  hFp: 1, hSyn: 1 + 1, hBp: 1, vAct: 3, vFp: 1, vSyn: 1, vBp: 1,
               hPol: 1'b0, vPol: 1'b0, dly: 2, fcw: 2};
    cfg[1] = '{hAct: 16, hFp: 3, hSyn: 5, hBp: 4, vAct: 6, vFp: 2, vSyn: 2, vBp: 3,
               hPol: 1'b1, vPol: 1'b0, dly: 0, fcw: 3};
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0; mv[i] = 0; mfc[i] = 0;
    end

    // Reset held three cycles, then free-running long enough for B's
    // 3-bit frame counter to wrap.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 3200; i++) drive(1'b1, 1'b1);

    // Enable dropped mid-frame for five cycles.
    for (int k = 0; k < 1000 && !(mv[1] == 3 && mh[1] == 10); k++) drive(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) drive(1'b1, 1'b1);

    // Reset pulsed while B is inside its vsync lines.
    for (int k = 0; k < 1000 && !(mv[1] == 8 && mh[1] == 7); k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 200; i++) drive(1'b1, 1'b1);

    // Reset pulsed while A is inside its vsync line.
    for (int k = 0; k < 1000 && !(mv[0] == 4 && mh[0] == 2); k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1);

    // Randomised reset pulses and enable gaps of 1..6 cycles.
    dis = 0;
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 249) != 0);
      if (dis == 0 && $urandom_range(0, 79) == 0) dis = $urandom_range(1, 6);
      en = (dis == 0);
      if (dis > 0) dis--;
      drive(rn, en);
    end
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);

    @(posedge clk40);
    #2;
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
